tia_player_position_counter: RTL and testbench
==============================================

# tia_player_position_counter

Horizontal position counter for one TIA player object, sitting directly upstream of `tia_player_graphics_scan_counter`. It counts 160 motion-clock-enabled colour clocks per line and decodes NUSIZ copy positions into the `start_bar` launch strobe. It also produces the `count_bar` scan-rate enable for single, double or quad width, and the `fstob` main-copy flag. RESPx repositioning is folded in; HMOVE extra clocks arrive upstream as additional `motck` pulses.

## Interface
- No parameters.
- `clock` in 1: colour clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `motck` in 1: motion enable; the counter advances only on cycles where it is high.
- `resp` in 1: one-cycle RESPx strobe.
- `nusiz` in 3: NUSIZx[2:0] copy/size code.
- `start_bar` out 1: active-low copy launch, to the scan counter.
- `count_bar` out 1: active-low scan advance enable, to the scan counter.
- `fstob` out 1: low while the main (first) copy is being scanned.

## Operation
- State:
  - `phase[1:0]`: divide-by-4.
  - `count[5:0]`: 0..39.
  - `suppress`: 1 bit.
  - Line position is `count*4+phase`, in the range 0..159.
- Advance rule, on cycles where `motck`=1:
  - `phase` increments.
  - If `phase`==3, `count` advances to `count`==39 ? 0 : `count`+1.
  - When `count` wraps 39→0, `suppress` clears.
  - When `motck`=0, all state holds.
- `resp`=1, independent of `motck`:
  - `count`=0, `phase`=0, `suppress`=1.
  - `resp` takes priority over the advance rule.
- `reset`=1 performs the same load as `resp`, at the same priority.
- Copy start counts by `nusiz` (main copy = count 0):
  - 000: {0}
  - 001: {0,4}
  - 010: {0,8}
  - 011: {0,4,8}
  - 100: {0,16}
  - 101: {0}
  - 110: {0,8,16}
  - 111: {0}
- `start_bar` = 0 when `count` ∈ the set for the current `nusiz` AND NOT (`count`==0 AND `suppress`=1).
  - As a result, a start lasts exactly the 4 enabled clocks of that count value.
- Scale:
  - `nusiz`=101 gives scale 2.
  - `nusiz`=111 gives scale 4.
  - All other codes give scale 1.
- `count_bar` = 0 when `motck`=1 AND one of:
  - scale 1;
  - scale 2 AND `phase[0]`=1;
  - scale 4 AND `phase`=3.
- `fstob` = 0 when `suppress`=0 AND `count` < 2×scale (main copy covers 8×scale pixels); otherwise 1.
- `nusiz` changes take effect immediately in the decode. Mid-copy changes produce truncated or extended copies, matching hardware.
- Values after `reset`: `start_bar`=0 is masked by `suppress`, so `start_bar`=1, `count_bar` = ~`motck`, and `fstob`=1.

## Timing
- Outputs are a combinational decode of registered state plus `nusiz` and `motck`.
  - No path from `resp` or `reset` to any output.
  - 0-cycle latency relative to state.
- `resp` at edge N: outputs reflect `count`=0 with `suppress` set from cycle N+1.
- Simultaneous `resp` and wrap: `resp` wins, and `suppress` stays 1.
- `reset` mid-copy: `start_bar` and `fstob` return to 1 on the next cycle.
- Line period is exactly 160 enabled clocks. Extra `motck` pulses during HMOVE shift the object left by one pixel each.

## Structure
- Shared header `tia_player_defs.v`:
  - `` `define`` codes for the 8 NUSIZ values;
  - `` `TIA_POS_COUNT_MAX`` (39);
  - copy offsets 4, 8, 16.
- Sub-module `tia_position_counter_core`: `phase` + mod-40 `count` + wrap pulse. It is reused by the missile and ball counters.
- The top level adds `suppress`, the NUSIZ decode and the output logic.

## Test plan
- `reset`, then `nusiz`=000, `motck`=1 continuous:
  - `start_bar`=1 for enabled clocks 0..159 (main copy suppressed).
  - `start_bar`=0 at clocks 160..163, 320..323.
  - `fstob`=0 at clocks 160..167.
- `nusiz`=011, free running after the first wrap: `start_bar` low at line offsets 0..3, 16..19, 32..35; `fstob` low only at offsets 0..7.
- `nusiz`=111: `count_bar` low on 1 of every 4 enabled clocks (`phase`=3); `fstob` low for offsets 0..31; one start per line.
- `nusiz`=001, `resp` at `count`=20:
  - Next 160 enabled clocks show only the copy at offsets 16..19.
  - The following line has the main copy at offset 160 after `resp`.
- `motck` toggling 1,0,0,1,…: state and `start_bar` hold across low cycles; `count_bar`=1 whenever `motck`=0; line length is 160 high cycles.
- `reset` asserted during the main copy (`count`=1): the next cycle has `start_bar`=1, `fstob`=1, `count`=0, `suppress`=1. `resp` coincident with wrap leaves `suppress`=1.

Source files
------------

// File: rtl/tia_player_position_counter_pkg.sv
// rtl/tia_player_position_counter_pkg.sv - NUSIZ codes, copy offsets and decode helpers for the player position counter
package tia_player_position_counter_pkg;

    localparam logic [5:0] POS_COUNT_MAX     = 6'd39;
    localparam logic [5:0] COPY_OFFSET_CLOSE = 6'd4;
    localparam logic [5:0] COPY_OFFSET_MED   = 6'd8;
    localparam logic [5:0] COPY_OFFSET_WIDE  = 6'd16;

    typedef enum logic [2:0] {
        NUSIZ_ONE         = 3'b000,
        NUSIZ_TWO_CLOSE   = 3'b001,
        NUSIZ_TWO_MED     = 3'b010,
        NUSIZ_THREE_CLOSE = 3'b011,
        NUSIZ_TWO_WIDE    = 3'b100,
        NUSIZ_DOUBLE      = 3'b101,
        NUSIZ_THREE_MED   = 3'b110,
        NUSIZ_QUAD        = 3'b111
    } nusiz_t;

    typedef enum logic [1:0] {
        SCALE_1 = 2'd0,
        SCALE_2 = 2'd1,
        SCALE_4 = 2'd2
    } scale_t;

    // True when count is the first count value of any copy for this code.
    function automatic logic copy_start(input nusiz_t code, input logic [5:0] count);
        logic hit;
        hit = (count == 6'd0);
        case (code)
            NUSIZ_TWO_CLOSE:   hit = hit || (count == COPY_OFFSET_CLOSE);
            NUSIZ_TWO_MED:     hit = hit || (count == COPY_OFFSET_MED);
            NUSIZ_THREE_CLOSE: hit = hit || (count == COPY_OFFSET_CLOSE) || (count == COPY_OFFSET_MED);
            NUSIZ_TWO_WIDE:    hit = hit || (count == COPY_OFFSET_WIDE);
            NUSIZ_THREE_MED:   hit = hit || (count == COPY_OFFSET_MED) || (count == COPY_OFFSET_WIDE);
            default:           hit = hit;
        endcase
        return hit;
    endfunction

    function automatic scale_t nusiz_scale(input nusiz_t code);
        case (code)
            NUSIZ_DOUBLE: return SCALE_2;
            NUSIZ_QUAD:   return SCALE_4;
            default:      return SCALE_1;
        endcase
    endfunction

endpackage

// File: rtl/tia_player_position_counter_if.sv
// rtl/tia_player_position_counter_if.sv - motion/position controls and scan-counter outputs of the player position counter
interface tia_player_position_counter_if;
    logic       motck;
    logic       resp;
    logic [2:0] nusiz;
    logic       start_bar;
    logic       count_bar;
    logic       fstob;

    modport master (
        output motck, resp, nusiz,
        input  start_bar, count_bar, fstob
    );

    modport slave (
        input  motck, resp, nusiz,
        output start_bar, count_bar, fstob
    );
endinterface

// File: rtl/tia_player_position_counter_core.sv
// rtl/tia_player_position_counter_core.sv - divide-by-4 phase plus mod-40 count shared by player, missile and ball counters
import tia_player_position_counter_pkg::*;

module tia_position_counter_core (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [1:0] phase,
    output logic [5:0] count,
    output logic       wrap
);

    assign wrap = advance && (phase == 2'd3) && (count == POS_COUNT_MAX);

    always_ff @(posedge clock) begin
        if (reset || load) begin
            phase <= 2'd0;
            count <= 6'd0;
        end else if (advance) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                count <= (count == POS_COUNT_MAX) ? 6'd0 : count + 6'd1;
            end
        end
    end

endmodule

// File: rtl/tia_player_position_counter.sv
// rtl/tia_player_position_counter.sv - player horizontal position counter with NUSIZ copy decode and scan-rate enable
import tia_player_position_counter_pkg::*;

module tia_player_position_counter (
    input  logic                         clock,
    input  logic                         reset,
    tia_player_position_counter_if.slave bus
);

    logic [1:0] phase;
    logic [5:0] count;
    logic       wrap;
    logic       suppress;
    nusiz_t     code;
    scale_t     scale;
    logic [5:0] main_span;

    tia_position_counter_core u_core (
        .clock   (clock),
        .reset   (reset),
        .load    (bus.resp),
        .advance (bus.motck),
        .phase   (phase),
        .count   (count),
        .wrap    (wrap)
    );

    // Suppress masks the main copy on the line RESPx was struck; load wins over wrap.
    always_ff @(posedge clock) begin
        if (reset || bus.resp) begin
            suppress <= 1'b1;
        end else if (wrap) begin
            suppress <= 1'b0;
        end
    end

    assign code  = nusiz_t'(bus.nusiz);
    assign scale = nusiz_scale(code);

    always_comb begin
        main_span = 6'd2;
        case (scale)
            SCALE_2: main_span = 6'd4;
            SCALE_4: main_span = 6'd8;
            default: main_span = 6'd2;
        endcase
    end

    always_comb begin
        bus.start_bar = 1'b1;
        bus.count_bar = 1'b1;
        bus.fstob     = 1'b1;
        if (copy_start(code, count) && !((count == 6'd0) && suppress)) begin
            bus.start_bar = 1'b0;
        end
        if (bus.motck) begin
            case (scale)
                SCALE_2: bus.count_bar = ~phase[0];
                SCALE_4: bus.count_bar = ~(phase == 2'd3);
                default: bus.count_bar = 1'b0;
            endcase
        end
        if (!suppress && (count < main_span)) begin
            bus.fstob = 1'b0;
        end
    end

endmodule

// File: tb/tb_tia_player_position_counter.sv
// tb/tb_tia_player_position_counter.sv - self-checking bench against a pixel-level line model
module tb_tia_player_position_counter;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   m_pos;
    bit   m_sup;

    tia_player_position_counter_if bus ();

    tia_player_position_counter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: pixel position along a 160-pixel line and whether the main copy is masked.
    function automatic int scale_of(input logic [2:0] nz);
        if (nz == 3'b101) return 2;
        if (nz == 3'b111) return 4;
        return 1;
    endfunction

    function automatic logic exp_start_bar(input logic [2:0] nz, input int pos, input bit sup);
        int offs[$];
        case (nz)
            3'b001:  offs = '{0, 16};
            3'b010:  offs = '{0, 32};
            3'b011:  offs = '{0, 16, 32};
            3'b100:  offs = '{0, 64};
            3'b110:  offs = '{0, 32, 64};
            default: offs = '{0};
        endcase
        foreach (offs[i]) begin
            if (pos >= offs[i] && pos < offs[i] + 4 && !(offs[i] == 0 && sup)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_count_bar(input logic [2:0] nz, input logic mck, input int pos);
        int s;
        s = scale_of(nz);
        return !(mck && (pos % s == s - 1));
    endfunction

    function automatic logic exp_fstob(input logic [2:0] nz, input int pos, input bit sup);
        return !(!sup && pos < 8 * scale_of(nz));
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b pos=%0d sup=%0d nusiz=%b", tag, obs, exp, m_pos, m_sup, bus.nusiz);
        end
    endtask

    task automatic model_edge();
        if (reset || bus.resp) begin
            m_pos = 0;
            m_sup = 1'b1;
        end else if (bus.motck) begin
            m_pos = m_pos + 1;
            if (m_pos == 160) begin
                m_pos = 0;
                m_sup = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check("start_bar", bus.start_bar, exp_start_bar(bus.nusiz, m_pos, m_sup));
        check("count_bar", bus.count_bar, exp_count_bar(bus.nusiz, bus.motck, m_pos));
        check("fstob", bus.fstob, exp_fstob(bus.nusiz, m_pos, m_sup));
    endtask

    // Inputs are set just after an edge; outputs checked mid-cycle, then the edge is taken.
    task automatic step(input bit do_check);
        #2;
        if (do_check) check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic run_until(input int target, input bit want_sup, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_pos == target && m_sup == want_sup) found = 1'b1;
            else step(1'b1);
        end
        check(tag, found, 1'b1);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        m_pos     = 0;
        m_sup     = 1'b1;
        reset     = 1'b1;
        bus.motck = 1'b1;
        bus.resp  = 1'b0;
        bus.nusiz = 3'b000;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        #2;
        check("reset_start_bar", bus.start_bar, 1'b1);
        check("reset_fstob", bus.fstob, 1'b1);
        check("reset_count_bar", bus.count_bar, 1'b0);

        run(330);
        bus.nusiz = 3'b011;
        run(200);
        bus.nusiz = 3'b111;
        run(170);

        bus.nusiz = 3'b001;
        run_until(80, 1'b0, "reach_count20");
        bus.resp = 1'b1;
        step(1'b1);
        bus.resp = 1'b0;
        run(330);

        bus.nusiz = 3'b000;
        for (int i = 0; i < 500; i++) begin
            bus.motck = (i % 3 == 0);
            step(1'b1);
        end
        bus.motck = 1'b1;

        run_until(4, 1'b0, "reach_main_copy");
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        #2;
        check("midcopy_reset_start_bar", bus.start_bar, 1'b1);
        check("midcopy_reset_fstob", bus.fstob, 1'b1);
        run(170);

        run_until(159, 1'b0, "reach_wrap");
        bus.resp = 1'b1;
        step(1'b1);
        bus.resp = 1'b0;
        #2;
        check("resp_wrap_fstob", bus.fstob, 1'b1);
        check("resp_wrap_start_bar", bus.start_bar, 1'b1);
        run(10);

        for (int i = 0; i < 3000; i++) begin
            bus.motck = ($urandom_range(0, 3) != 0);
            bus.resp  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) bus.nusiz = 3'($urandom_range(0, 7));
            step(1'b1);
        end
        bus.resp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
